// File: rtl/framebuffer_read_sequencer.sv
// -----------------------------------------------------------------------------
// framebuffer_read_sequencer
//
// Read-side initiator for the DDR framebuffer, clk_ui domain.
// A frame_start_in pulse makes the block walk chunk indices 0 .. FRAME_WORDS-1
// on the AXI read-address channel, in order, one request per 128-bit chunk.
// A credit counter limits the number of accepted addresses whose data beat
// has not yet come back. The read-data handshake is only snooped: it is
// counted so that the frame's final beat can be flagged to the read-data FIFO
// and so that the end of the frame can be reported.
//
// Handshake rule (both channels): a transfer happens in a cycle where valid
// and ready are both high. Once ar_valid_out rises it stays high, with
// ar_addr_out unchanged, until the cycle in which ar_ready_in is also high.
//
// Ports
//   clk_in               : clock
//   rst_n_in             : asynchronous active-low reset
//   frame_start_in       : one-cycle request for one full-frame read
//   ar_valid_out         : read-address valid
//   ar_ready_in          : read-address ready
//   ar_addr_out          : chunk index being requested
//   r_valid_in           : read-data valid (snooped)
//   r_ready_in           : read-data ready (snooped)
//   last_frame_chunk_out : high while the frame's final beat is on the bus
//   busy_out             : a frame is in progress
//   frame_done_out       : one-cycle pulse after the final beat is accepted
//   frame_overrun_out    : one-cycle pulse when a start arrives while busy
//   dbg_state_out        : current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module framebuffer_read_sequencer #(
    parameter int FRAME_WORDS     = 57600,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_W          = 22
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_start_in,
    output logic              ar_valid_out,
    input  logic              ar_ready_in,
    output logic [ADDR_W-1:0] ar_addr_out,
    input  logic              r_valid_in,
    input  logic              r_ready_in,
    output logic              last_frame_chunk_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              frame_overrun_out,
    output logic [1:0]        dbg_state_out
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_WORDS);
    localparam logic [OUT_W-1:0] MAX_CREDIT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_received;
    logic [OUT_W-1:0] r_outstanding;
    logic             r_done;
    logic             r_overrun;

    logic             w_busy;
    logic             w_ar_valid;
    logic             w_ar_fire;
    logic             w_r_fire;
    logic             w_last_beat_fire;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_ar_fire = w_ar_valid & ar_ready_in;

    // Beats are only meaningful while a frame is running; anything seen in
    // IDLE is ignored entirely.
    assign w_r_fire = w_busy & r_valid_in & r_ready_in;

    assign w_last_beat_fire = w_r_fire & (r_received == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    // ar_valid can be taken straight from the credit compare: while it is
    // high and no address is accepted, the credit count can only fall, so
    // the compare stays true and valid cannot drop before the transfer.
    // The address is the issue counter, which only moves on a transfer.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_ar_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start_in) begin
                    w_state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_busy     = 1'b1;
                w_ar_valid = (r_outstanding < MAX_CREDIT);
                if ((w_ar_valid & ar_ready_in) && (r_issued == LAST_IDX)) begin
                    w_state_next = S_DRAIN;
                end
            end

            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_valid_in && r_ready_in && (r_received == LAST_IDX)) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
        end else if (r_state == S_IDLE) begin
            if (frame_start_in) begin
                r_issued      <= '0;
                r_received    <= '0;
                r_outstanding <= '0;
            end
        end else begin
            if (w_ar_fire && (r_issued != FRAME_CNT)) begin
                r_issued <= r_issued + CNT_W'(1);
            end

            if (w_r_fire && (r_received != FRAME_CNT)) begin
                r_received <= r_received + CNT_W'(1);
            end

            // A credit taken and a credit returned in the same cycle cancel.
            case ({w_ar_fire, w_r_fire})
                2'b10: begin
                    if (r_outstanding != MAX_CREDIT) begin
                        r_outstanding <= r_outstanding + OUT_W'(1);
                    end
                end
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - OUT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    // frame_done rises in the cycle after the final beat, which is also the
    // first IDLE cycle, so a start arriving together with it is accepted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= w_last_beat_fire & (r_state == S_DRAIN);
            r_overrun <= frame_start_in & w_busy;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ar_valid_out         = w_ar_valid;
    assign ar_addr_out          = ADDR_W'(r_issued);
    assign busy_out             = w_busy;
    // Qualified by valid only, so the FIFO sees the flag for as long as the
    // final beat is presented, including cycles it is back-pressuring.
    assign last_frame_chunk_out = w_busy & r_valid_in & (r_received == LAST_IDX);
    assign frame_done_out       = r_done;
    assign frame_overrun_out    = r_overrun;
    assign dbg_state_out        = r_state;

endmodule

// File: tb/tb_framebuffer_read_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for framebuffer_read_sequencer.
// Main instance: FRAME_WORDS=8, MAX_OUTSTANDING=4. Second instance:
// FRAME_WORDS=1, MAX_OUTSTANDING=1.
// A memory responder returns one beat per accepted address, in order, after a
// programmable latency. A monitor on the falling edge keeps a frame-level
// reference (requests issued, beats returned, frame active) and compares every
// DUT output against it; expected addresses sit in a queue filled when a
// frame start is accepted.
// -----------------------------------------------------------------------------
module tb_framebuffer_read_sequencer;

  localparam int FW = 8;
  localparam int MO = 4;
  localparam int AW = 22;
  localparam int WAIT_LIMIT = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;

  // ---------------- main DUT ----------------
  logic          frame_start;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic          r_valid;
  logic          r_ready;
  logic          last;
  logic          busy;
  logic          done;
  logic          ovr;
  logic [1:0]    dbg;

  framebuffer_read_sequencer #(
    .FRAME_WORDS(FW), .MAX_OUTSTANDING(MO), .ADDR_W(AW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
    .ar_valid_out(ar_valid), .ar_ready_in(ar_ready), .ar_addr_out(ar_addr),
    .r_valid_in(r_valid), .r_ready_in(r_ready), .last_frame_chunk_out(last),
    .busy_out(busy), .frame_done_out(done), .frame_overrun_out(ovr),
    .dbg_state_out(dbg)
  );

  // ---------------- single-chunk DUT ----------------
  logic          fs1;
  logic          ar_valid1;
  logic          arr1;
  logic [AW-1:0] addr1;
  logic          rv1;
  logic          rr1;
  logic          last1;
  logic          busy1;
  logic          done1;
  logic          ovr1;
  logic [1:0]    dbg1;

  framebuffer_read_sequencer #(
    .FRAME_WORDS(1), .MAX_OUTSTANDING(1), .ADDR_W(AW)
  ) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(fs1),
    .ar_valid_out(ar_valid1), .ar_ready_in(arr1), .ar_addr_out(addr1),
    .r_valid_in(rv1), .r_ready_in(rr1), .last_frame_chunk_out(last1),
    .busy_out(busy1), .frame_done_out(done1), .frame_overrun_out(ovr1),
    .dbg_state_out(dbg1)
  );

  // ---------------- scoreboard / reference state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_addr_q[$];
  int            mem_q[$];      // ready cycle of each in-flight beat

  bit m_busy = 1'b0;
  int m_iss  = 0;
  int m_rcv  = 0;
  bit exp_done = 1'b0;
  bit exp_ovr  = 1'b0;

  int frame_ar_cnt = 0;
  int r_fire_cnt   = 0;
  int done_cnt     = 0;
  int ovr_cnt      = 0;

  // responder controls
  bit mem_hold    = 1'b0;
  int release_cnt = 0;
  int lat         = 3;
  bit lat_rand    = 1'b0;
  bit rr_random   = 1'b0;
  bit ar_random   = 1'b0;
  bit stray_r     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || m_busy) && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    check(name, 32'(n < WAIT_LIMIT), 32'd1);
    step();
  endtask

  // ---------------- memory responder ----------------
  initial begin
    r_valid = 1'b0;
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stray_r) begin
        r_valid = 1'b1;
        r_ready = 1'b1;
      end else begin
        r_valid = (mem_q.size() > 0) && (mem_q[0] <= cyc) && (!mem_hold || release_cnt > 0);
        r_ready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (ar_random) ar_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit busy_now;
    bit ar_f;
    bit r_f;
    int t;
    if (!rst_n) begin
      check("rst_ar_valid", 32'(ar_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_last", 32'(last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overrun", 32'(ovr), 32'd0);
      m_busy = 1'b0;
      m_iss = 0;
      m_rcv = 0;
      exp_done = 1'b0;
      exp_ovr = 1'b0;
      release_cnt = 0;
      exp_addr_q.delete();
      mem_q.delete();
    end else begin
      busy_now = m_busy;
      ar_f = ar_valid && ar_ready;
      r_f = r_valid && r_ready;

      check("busy", 32'(busy), 32'(m_busy));
      check("dbg_state_active", 32'(dbg != 2'd0), 32'(m_busy));
      check("ar_valid", 32'(ar_valid), 32'(m_busy && (m_iss < FW) && ((m_iss - m_rcv) < MO)));
      if (ar_valid && exp_addr_q.size() > 0) check("ar_addr", 32'(ar_addr), 32'(exp_addr_q[0]));
      check("last_flag", 32'(last), 32'(m_busy && r_valid && (m_rcv == FW - 1)));
      check("frame_done", 32'(done), 32'(exp_done));
      check("overrun", 32'(ovr), 32'(exp_ovr));
      if (done) done_cnt++;
      if (ovr) ovr_cnt++;
      exp_done = 1'b0;
      exp_ovr = 1'b0;

      if (ar_f) begin
        frame_ar_cnt++;
        m_iss++;
        if (exp_addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ar: got addr %0d, expected no request (cycle %0d)", ar_addr, cyc);
        end else begin
          void'(exp_addr_q.pop_front());
        end
        t = cyc + (lat_rand ? $urandom_range(1, lat) : lat);
        if (mem_q.size() > 0 && t < mem_q[$]) t = mem_q[$];
        mem_q.push_back(t);
      end

      if (r_f) begin
        r_fire_cnt++;
        if (!stray_r && mem_q.size() > 0) begin
          void'(mem_q.pop_front());
          if (release_cnt > 0) release_cnt--;
        end
        if (busy_now) begin
          m_rcv++;
          if (m_rcv == FW) begin
            m_busy = 1'b0;
            exp_done = 1'b1;
          end
        end
      end

      if (frame_start) begin
        if (busy_now) begin
          exp_ovr = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_iss = 0;
          m_rcv = 0;
          frame_ar_cnt = 0;
          for (int i = 0; i < FW; i++) exp_addr_q.push_back(AW'(i));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int o0;
    int n;
    int r0;
    logic [AW-1:0] a0;

    rst_n = 1'b0;
    frame_start = 1'b0;
    ar_ready = 1'b0;
    fs1 = 1'b0;
    arr1 = 1'b0;
    rv1 = 1'b0;
    rr1 = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // stray beats while idle are ignored
    stray_r = 1'b1;
    repeat (3) step();
    stray_r = 1'b0;
    step();

    // basic frame
    ar_ready = 1'b1;
    lat = 3;
    d0 = done_cnt;
    start_frame();
    check("start_latency_valid", 32'(ar_valid), 32'd1);
    check("start_latency_addr", 32'(ar_addr), 32'd0);
    wait_idle("basic_complete");
    check("basic_ar_count", 32'(frame_ar_cnt), 32'(FW));
    check("basic_done_once", 32'(done_cnt - d0), 32'd1);
    check("basic_busy_after", 32'(busy), 32'd0);

    // credit stall: no data returns
    mem_hold = 1'b1;
    start_frame();
    repeat (10) step();
    check("credit_fires", 32'(frame_ar_cnt), 32'(MO));
    check("credit_valid_low", 32'(ar_valid), 32'd0);
    r0 = r_fire_cnt;
    release_cnt = 1;
    n = 0;
    while (r_fire_cnt == r0 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    check("credit_release_seen", 32'(n < WAIT_LIMIT), 32'd1);
    check("credit_reissue_valid", 32'(ar_valid), 32'd1);
    check("credit_reissue_addr", 32'(ar_addr), 32'(MO));
    mem_hold = 1'b0;
    wait_idle("credit_complete");

    // simultaneous AR and R fire at outstanding = 2
    mem_hold = 1'b1;
    lat = 1;
    ar_ready = 1'b0;
    start_frame();
    ar_ready = 1'b1;
    step();
    step();
    release_cnt = 1;
    step();
    repeat (8) step();
    check("simul_ar_count", 32'(frame_ar_cnt), 32'd5);
    check("simul_valid_low", 32'(ar_valid), 32'd0);
    mem_hold = 1'b0;
    lat = 3;
    wait_idle("simul_complete");

    // AR backpressure
    start_frame();
    step();
    step();
    ar_ready = 1'b0;
    a0 = ar_addr;
    check("bp_addr_start", 32'(a0), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(ar_valid), 32'd1);
      check("bp_addr_stable", 32'(ar_addr), 32'(a0));
      step();
    end
    ar_ready = 1'b1;
    wait_idle("bp_complete");
    check("bp_ar_count", 32'(frame_ar_cnt), 32'(FW));

    // overrun in DRAIN, then restart in the done cycle
    o0 = ovr_cnt;
    start_frame();
    n = 0;
    while (m_iss < FW && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    check("ovr_reach_drain", 32'(n < WAIT_LIMIT), 32'd1);
    start_frame();
    check("ovr_pulse", 32'(ovr), 32'd1);
    n = 0;
    while (!done && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    check("ovr_done_seen", 32'(done), 32'd1);
    start_frame();
    check("restart_valid", 32'(ar_valid), 32'd1);
    check("restart_addr", 32'(ar_addr), 32'd0);
    wait_idle("restart_complete");
    check("ovr_once", 32'(ovr_cnt - o0), 32'd1);

    // reset in the middle of a frame
    start_frame();
    n = 0;
    while (frame_ar_cnt < 3 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ar_valid", 32'(ar_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_last", 32'(last), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_ovr", 32'(ovr), 32'd0);
    mem_q.delete();
    release_cnt = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    start_frame();
    check("post_rst_addr", 32'(ar_addr), 32'd0);
    check("post_rst_valid", 32'(ar_valid), 32'd1);
    wait_idle("post_rst_complete");

    // randomized frames with AR and R backpressure
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 6);
      lat_rand = 1'b1;
      ar_random = 1'b1;
      rr_random = 1'b1;
      start_frame();
      wait_idle("rand_complete");
      check("rand_ar_count", 32'(frame_ar_cnt), 32'(FW));
    end
    ar_random = 1'b0;
    rr_random = 1'b0;
    lat_rand = 1'b0;
    ar_ready = 1'b1;
    step();

    // single-chunk frame
    check("fw1_idle_valid", 32'(ar_valid1), 32'd0);
    fs1 = 1'b1;
    step();
    fs1 = 1'b0;
    check("fw1_valid", 32'(ar_valid1), 32'd1);
    check("fw1_addr", 32'(addr1), 32'd0);
    check("fw1_busy", 32'(busy1), 32'd1);
    arr1 = 1'b1;
    step();
    arr1 = 1'b0;
    check("fw1_drain_valid", 32'(ar_valid1), 32'd0);
    check("fw1_drain_busy", 32'(busy1), 32'd1);
    check("fw1_drain_dbg", 32'(dbg1 != 2'd0), 32'd1);
    check("fw1_no_last_yet", 32'(last1), 32'd0);
    rv1 = 1'b1;
    rr1 = 1'b1;
    #1;
    check("fw1_last", 32'(last1), 32'd1);
    step();
    rv1 = 1'b0;
    rr1 = 1'b0;
    #1;
    check("fw1_done", 32'(done1), 32'd1);
    check("fw1_busy_after", 32'(busy1), 32'd0);
    check("fw1_last_after", 32'(last1), 32'd0);
    step();
    check("fw1_done_one_cycle", 32'(done1), 32'd0);
    check("fw1_no_overrun", 32'(ovr1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
